// File: rtl/tl_burst_lock_arbiter.sv
// N:1 round-robin arbiter for TileLink A/C channels. Once a requester wins, the grant stays
// with it until the last beat of its message has been accepted, so messages never interleave.
module tl_burst_lock_arbiter #(
  parameter int  N_MASTER   = 2,
  parameter type DATA_T     = logic [63:0],
  parameter int  SIZE_W     = 4,
  parameter int  BEAT_BYTES = 8,
  parameter int  MAX_SIZE   = 6,
  localparam int LOG2_BEAT  = $clog2(BEAT_BYTES),
  localparam int CNT_W      = (MAX_SIZE - LOG2_BEAT > 1) ? (MAX_SIZE - LOG2_BEAT) : 1,
  localparam int SEL_W      = $clog2(N_MASTER)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_MASTER-1:0] inp_valid_i,
  output logic [N_MASTER-1:0] inp_ready_o,
  input  DATA_T               inp_bits_i [N_MASTER],
  input  logic [SIZE_W-1:0]   inp_size_i [N_MASTER],
  input  logic [N_MASTER-1:0] inp_has_data_i,
  output logic                oup_valid_o,
  input  logic                oup_ready_i,
  output DATA_T               oup_bits_o,
  output logic [SEL_W-1:0]    oup_sel_o,
  output logic                oup_first_o,
  output logic                oup_last_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;

  logic [1:0]       r_state;
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] r_gnt;
  logic [CNT_W-1:0] r_cnt;

  logic [SEL_W-1:0] w_sel;
  logic [CNT_W-1:0] w_selBeatsM1;
  logic             w_anyValid;
  logic             w_fire;

  // Beats minus one for a message; sizes above MAX_SIZE saturate, data-less messages are one beat.
  function automatic logic [CNT_W-1:0] beatsM1(input logic [SIZE_W-1:0] size, input logic hasData);
    int sz;
    int beats;
    sz = int'(size);
    if (sz > MAX_SIZE) sz = MAX_SIZE;
    beats = 0;
    if (hasData && (sz > LOG2_BEAT)) beats = (1 << (sz - LOG2_BEAT)) - 1;
    return CNT_W'(beats);
  endfunction

  function automatic logic [SEL_W-1:0] nextIdx(input logic [SEL_W-1:0] idx);
    if (int'(idx) == N_MASTER - 1) return '0;
    return idx + SEL_W'(1);
  endfunction

  assign w_anyValid = |inp_valid_i;

  // First asserted valid at or after the round-robin pointer, wrapping at N_MASTER.
  always_comb begin
    int   idx;
    logic found;
    w_sel = r_ptr;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_MASTER; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= N_MASTER) idx = idx - N_MASTER;
      if (!found && inp_valid_i[SEL_W'(idx)]) begin
        w_sel = SEL_W'(idx);
        found = 1'b1;
      end
    end
  end

  assign w_selBeatsM1 = beatsM1(inp_size_i[w_sel], inp_has_data_i[w_sel]);

  always_comb begin
    oup_valid_o = 1'b0;
    oup_sel_o   = '0;
    oup_first_o = 1'b0;
    oup_last_o  = 1'b0;
    inp_ready_o = '0;
    if (!rst_i) begin
      case (r_state)
        ST_HOLD: begin
          oup_sel_o          = r_gnt;
          oup_valid_o        = inp_valid_i[r_gnt];
          oup_first_o        = 1'b1;
          oup_last_o         = (r_cnt == '0);
          inp_ready_o[r_gnt] = oup_ready_i;
        end
        ST_BURST: begin
          oup_sel_o          = r_gnt;
          oup_valid_o        = inp_valid_i[r_gnt];
          oup_first_o        = 1'b0;
          oup_last_o         = (r_cnt == '0);
          inp_ready_o[r_gnt] = oup_ready_i;
        end
        default: begin
          oup_sel_o          = w_sel;
          oup_valid_o        = w_anyValid;
          oup_first_o        = 1'b1;
          oup_last_o         = (w_selBeatsM1 == '0);
          inp_ready_o[w_sel] = oup_ready_i;
        end
      endcase
    end
  end

  assign oup_bits_o = inp_bits_i[oup_sel_o];
  assign w_fire     = oup_valid_o & oup_ready_i;

  // A first beat that stalls is frozen in HOLD so a later higher-priority valid cannot steal it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_anyValid) begin
            if (oup_ready_i) begin
              if (w_selBeatsM1 == '0) begin
                r_ptr <= nextIdx(w_sel);
              end else begin
                r_gnt   <= w_sel;
                r_cnt   <= w_selBeatsM1 - CNT_W'(1);
                r_state <= ST_BURST;
              end
            end else begin
              r_gnt   <= w_sel;
              r_cnt   <= w_selBeatsM1;
              r_state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (w_fire) begin
            if (r_cnt == '0) begin
              r_ptr   <= nextIdx(r_gnt);
              r_state <= ST_IDLE;
            end else begin
              r_cnt   <= r_cnt - CNT_W'(1);
              r_state <= ST_BURST;
            end
          end
        end
        ST_BURST: begin
          if (w_fire) begin
            if (r_cnt == '0) begin
              r_ptr   <= nextIdx(r_gnt);
              r_state <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tl_burst_lock_arbiter.sv
// Scoreboard bench for tl_burst_lock_arbiter: masters push expected beats when they issue a
// message; a negedge monitor predicts the grant from message-level locking rules and pops beats.
module tb_tl_burst_lock_arbiter;
  localparam int N         = 3;
  localparam int SW        = 2;
  localparam int MAX_SIZE  = 6;
  localparam int LOG2_BEAT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  inpValid;
  logic [N-1:0]  inpReady;
  logic [N-1:0]  inpHasData;
  logic [63:0]   inpBits [N];
  logic [3:0]    inpSize [N];
  logic          oupValid;
  logic          oupReady;
  logic [63:0]   oupBits;
  logic [SW-1:0] oupSel;
  logic          oupFirst;
  logic          oupLast;

  tl_burst_lock_arbiter #(.N_MASTER(N)) dut (
    .clk_i(clk), .rst_i(rst),
    .inp_valid_i(inpValid), .inp_ready_o(inpReady), .inp_bits_i(inpBits),
    .inp_size_i(inpSize), .inp_has_data_i(inpHasData),
    .oup_valid_o(oupValid), .oup_ready_i(oupReady), .oup_bits_o(oupBits),
    .oup_sel_o(oupSel), .oup_first_o(oupFirst), .oup_last_o(oupLast)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          m;
    logic [63:0] data;
    logic        first;
    logic        last;
  } beat_t;

  beat_t expQ[$];
  int    grantLog[$];
  int    expG[$];
  int    checks = 0;
  int    errors = 0;

  bit          active[N];
  bit          forcePause[N];
  int          beatIdx[N];
  int          msgBeats[N];
  int          serial[N];
  int          bubbleLeft[N];
  logic [3:0]  msgSize[N];
  logic        msgHasData[N];
  bit          randMode  = 1'b0;
  bit          randReady = 1'b0;
  logic        readyVal  = 1'b1;

  int mOwner = -1;
  int mPtr   = 0;

  function automatic int refBeats(input int size, input bit hasData);
    int sz;
    sz = (size > MAX_SIZE) ? MAX_SIZE : size;
    if (hasData && sz > LOG2_BEAT) return 2 ** (sz - LOG2_BEAT);
    return 1;
  endfunction

  function automatic logic [63:0] makeData(input int m, input int ser, input int b);
    return {8'(m), 24'(ser), 8'(b), 24'(ser * 7919 + b * 31 + m)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: at most one owner at a time; with no owner the first valid from the pointer wins.
  always @(negedge clk) begin
    int           es;
    bit           ev;
    int           hit;
    logic [N-1:0] er;
    if (rst) begin
      check("rst_valid", 64'(oupValid), 64'(0));
      check("rst_ready", 64'(inpReady), 64'(0));
      check("rst_first", 64'(oupFirst), 64'(0));
      check("rst_last",  64'(oupLast),  64'(0));
      check("rst_sel",   64'(oupSel),   64'(0));
      mOwner = -1;
      mPtr   = 0;
    end else begin
      es = -1;
      if (mOwner >= 0) begin
        es = mOwner;
        ev = inpValid[SW'(mOwner)];
      end else begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (mPtr + k) % N;
          if (es < 0 && inpValid[SW'(c)]) es = c;
        end
        ev = (es >= 0);
      end
      check("valid", 64'(oupValid), 64'(ev));
      if (es >= 0) begin
        er = '0;
        er[SW'(es)] = oupReady;
        check("ready_vec", 64'(inpReady), 64'(er));
      end
      if (ev) begin
        check("sel", 64'(oupSel), 64'(es));
        hit = -1;
        for (int i = 0; i < expQ.size(); i++)
          if (hit < 0 && expQ[i].m == es) hit = i;
        check("sb_pending", 64'(hit >= 0), 64'(1));
        if (hit >= 0) begin
          check("bits",  oupBits,         expQ[hit].data);
          check("first", 64'(oupFirst),   64'(expQ[hit].first));
          check("last",  64'(oupLast),    64'(expQ[hit].last));
          if (oupReady) begin
            if (expQ[hit].first) grantLog.push_back(es);
            if (expQ[hit].last) begin
              mOwner = -1;
              mPtr   = (es + 1) % N;
            end else begin
              mOwner = es;
            end
            expQ.delete(hit);
          end else begin
            mOwner = es;
          end
        end
      end
    end
  end

  task automatic drive();
    for (int m = 0; m < N; m++) begin
      inpValid[SW'(m)]   = active[m] && bubbleLeft[m] == 0 && !forcePause[m];
      inpBits[m]         = active[m] ? makeData(m, serial[m], beatIdx[m]) : {$urandom, $urandom};
      inpSize[m]         = (active[m] && beatIdx[m] == 0) ? msgSize[m] : 4'($urandom);
      inpHasData[SW'(m)] = (active[m] && beatIdx[m] == 0) ? msgHasData[m] : 1'($urandom);
    end
    oupReady = randReady ? ($urandom_range(0, 99) < 70) : readyVal;
  endtask

  task automatic startMsg(input int m, input int size, input bit hasData, input int gap);
    beat_t bt;
    active[m]     = 1'b1;
    beatIdx[m]    = 0;
    msgBeats[m]   = refBeats(size, hasData);
    serial[m]     = serial[m] + 1;
    bubbleLeft[m] = gap;
    msgSize[m]    = 4'(size);
    msgHasData[m] = hasData;
    for (int b = 0; b < msgBeats[m]; b++) begin
      bt.m     = m;
      bt.data  = makeData(m, serial[m], b);
      bt.first = (b == 0);
      bt.last  = (b == msgBeats[m] - 1);
      expQ.push_back(bt);
    end
  endtask

  task automatic stepCycle();
    logic [N-1:0] fired;
    @(negedge clk);
    fired = inpValid & inpReady;
    @(posedge clk);
    #1;
    for (int m = 0; m < N; m++) begin
      if (active[m]) begin
        if (fired[SW'(m)]) begin
          beatIdx[m]++;
          if (beatIdx[m] == msgBeats[m]) active[m] = 1'b0;
          else if (randMode && $urandom_range(0, 3) == 0) bubbleLeft[m] = int'($urandom_range(1, 2));
        end else if (bubbleLeft[m] > 0) begin
          bubbleLeft[m]--;
        end
      end
    end
    if (randMode)
      for (int m = 0; m < N; m++)
        if (!active[m] && $urandom_range(0, 2) == 0)
          startMsg(m, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    drive();
  endtask

  function automatic bit anyActive();
    for (int m = 0; m < N; m++) if (active[m]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic runUntilIdle(input int budget, input string name);
    int c;
    c = 0;
    while ((anyActive() || expQ.size() != 0) && c < budget) begin
      stepCycle();
      c++;
    end
    check({name, "_done"}, 64'(c < budget), 64'(1));
  endtask

  task automatic waitBeat(input int m, input int target, input int budget, input string name);
    int c;
    c = 0;
    while (beatIdx[m] < target && c < budget) begin
      stepCycle();
      c++;
    end
    check({name, "_reached"}, 64'(beatIdx[m] >= target), 64'(1));
  endtask

  task automatic checkGrants(input string name);
    check({name, "_grant_count"}, 64'(grantLog.size()), 64'(expG.size()));
    for (int i = 0; i < grantLog.size() && i < expG.size(); i++)
      check({name, "_grant"}, 64'(grantLog[i]), 64'(expG[i]));
    grantLog.delete();
  endtask

  task automatic resetPulse(input int cycles);
    rst = 1'b1;
    drive();
    repeat (cycles) stepCycle();
    for (int m = 0; m < N; m++) begin
      active[m]     = 1'b0;
      forcePause[m] = 1'b0;
      bubbleLeft[m] = 0;
    end
    expQ.delete();
    grantLog.delete();
    rst = 1'b0;
    drive();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int sent[N];
    for (int m = 0; m < N; m++) begin
      active[m] = 1'b0; forcePause[m] = 1'b0; beatIdx[m] = 0; msgBeats[m] = 0;
      serial[m] = 0; bubbleLeft[m] = 0; msgSize[m] = '0; msgHasData[m] = 1'b0; sent[m] = 0;
    end
    rst = 1'b1;
    drive();
    repeat (3) stepCycle();
    rst = 1'b0;
    drive();
    stepCycle();

    $display("[TB] single-beat Gets alternate");
    for (int i = 0; i < 4; i++) begin
      for (int m = 0; m < 2; m++)
        if (!active[m] && sent[m] < 2) begin
          startMsg(m, 3, 1'b0, 0);
          sent[m]++;
        end
      drive();
      stepCycle();
    end
    runUntilIdle(20, "t1");
    expG = '{0, 1, 0, 1};
    checkGrants("t1");

    $display("[TB] 8-beat PutFull blocks competing Get");
    startMsg(0, 6, 1'b1, 0);
    startMsg(1, 4, 1'b0, 0);
    drive();
    runUntilIdle(40, "t2");
    expG = '{0, 1};
    checkGrants("t2");

    $display("[TB] stalled grant stays frozen");
    startMsg(0, 0, 1'b0, 0);
    drive();
    runUntilIdle(10, "t3a");
    readyVal = 1'b0;
    startMsg(1, 2, 1'b0, 0);
    drive();
    repeat (2) stepCycle();
    startMsg(0, 3, 1'b0, 0);
    drive();
    repeat (3) stepCycle();
    readyVal = 1'b1;
    drive();
    runUntilIdle(20, "t3");
    expG = '{0, 1, 0};
    checkGrants("t3");

    $display("[TB] bubble inside a burst");
    startMsg(0, 5, 1'b1, 0);
    drive();
    stepCycle();
    startMsg(1, 3, 1'b0, 0);
    drive();
    waitBeat(0, 2, 10, "t4");
    forcePause[0] = 1'b1;
    drive();
    repeat (3) stepCycle();
    forcePause[0] = 1'b0;
    drive();
    runUntilIdle(20, "t4");
    expG = '{0, 1};
    checkGrants("t4");

    $display("[TB] reset in the middle of a burst");
    startMsg(0, 1, 1'b0, 0);
    drive();
    runUntilIdle(10, "t5a");
    startMsg(2, 6, 1'b1, 0);
    drive();
    waitBeat(2, 2, 10, "t5");
    startMsg(1, 3, 1'b0, 0);
    resetPulse(2);
    startMsg(0, 3, 1'b0, 0);
    startMsg(1, 3, 1'b0, 0);
    drive();
    runUntilIdle(20, "t5");
    expG = '{0, 1};
    checkGrants("t5");

    $display("[TB] small and oversize data messages");
    randReady = 1'b1;
    startMsg(1, 2, 1'b1, 0);
    startMsg(2, 9, 1'b1, 0);
    drive();
    runUntilIdle(80, "t6");
    expG = '{2, 1};
    checkGrants("t6");

    $display("[TB] random traffic");
    randMode = 1'b1;
    repeat (800) stepCycle();
    randMode = 1'b0;
    runUntilIdle(400, "drain");
    check("sb_empty", 64'(expQ.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
